multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multicycle control unit for the 16-bit MIPS-like datapath. Sequences each instruction through
//  FETCH/DECODE/EXECUTE/MEM/WB, drives the ALU (aluop, operand selects) and memory handshake.
//  Latches the ALU status flags {zero,carry,overflow,sign} into an architectural flag register.
//  Sits between the instruction register/memory interface and the ALU + register-file datapath.
// PARAMETERS
//  OPW      4  opcode width, instr[15:12]
//  STATEW   4  state register width
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-high reset
//  opcode     in   4   IR[15:12]; decoded in DECODE
//  alu_zero   in   1   live ALU zero flag
//  alu_carry  in   1   live ALU carry flag
//  alu_ovf    in   1   live ALU overflow flag
//  alu_sign   in   1   live ALU sign flag
//  mem_ready  in   1   memory done; sampled only while mem_req=1
//  mem_req    out  1   memory access request, held until mem_ready
//  mem_we     out  1   1=write (valid with mem_req)
//  iord       out  1   address select: 0=PC, 1=ALUOut
//  ir_we      out  1   load IR
//  pc_we      out  1   load PC
//  pc_src     out  2   00=ALU result, 01=ALUOut (branch target), 10=jump target
//  alu_src_a  out  1   0=PC, 1=regA
//  alu_src_b  out  2   00=regB, 01=const 1, 10=sign-ext imm
//  aluop      out  2   00=add, 01=subtract, 10=use IR functcode
//  reg_we     out  1   register-file write
//  reg_dst    out  1   0=rt, 1=rd
//  mem_to_reg out  1   writeback source: 0=ALUOut, 1=MDR
//  flags      out  4   registered {zero,carry,overflow,sign}
//  halted     out  1   in HALT
//  illegal    out  1   sticky: undefined opcode decoded
// BEHAVIOUR
//  Reset: state=FETCH; every output 0 (aluop=00, selects 00), flags=0, illegal=0; applies mid-instruction
//   and mid-handshake (mem_req drops at the reset edge, no PC/IR/reg/flag write that cycle).
//  Opcodes: 0 R-type, 1 addi, 2 lw, 3 sw, 4 beq, 5 bne, 6 blt, 7 j, F halt; others -> illegal=1, HALT.
//  FETCH: mem_req=1,iord=0,src_a=0,src_b=01,aluop=00; stall while !mem_ready; on mem_ready same cycle:
//   ir_we=1, pc_we=1, pc_src=00 (PC+1), next DECODE. Zero-wait memory accepted in first cycle.
//  DECODE: src_a=0,src_b=10,aluop=00 (ALUOut<=branch target); next by opcode: R->EXEC_R, addi->EXEC_I,
//   lw/sw->MEM_ADDR, beq/bne/blt->BRANCH, j->JUMP (pc_we=1,pc_src=10, next FETCH), halt->HALT.
//  EXEC_R: src_a=1,src_b=00,aluop=10, flag_we: flags<=live ALU flags; next WB_R.
//  EXEC_I: src_a=1,src_b=10,aluop=00, flags updated; next WB_I.
//  WB_R/WB_I: reg_we=1, mem_to_reg=0, reg_dst=1/0; next FETCH.
//  MEM_ADDR: src_a=1,src_b=10,aluop=00; next MEM_RD (lw) or MEM_WR (sw). Flags not updated.
//  MEM_RD: mem_req=1,iord=1; wait for mem_ready -> WB_MEM (reg_we=1,mem_to_reg=1,reg_dst=0) -> FETCH.
//  MEM_WR: mem_req=1,mem_we=1,iord=1; on mem_ready -> FETCH.
//  BRANCH: src_a=1,src_b=00,aluop=01 (rs-rt); taken: beq zero=1, bne zero=0, blt sign^ovf=1;
//   taken -> pc_we=1,pc_src=01; -> FETCH. Branch compare does not update flags.
//  HALT: all strobes 0, halted=1; exits only on reset.
//  Latency (zero-wait mem): R/addi 4, lw 5, sw 4, branch 3, j 3 cycles. Each mem wait adds 1.
//  mem_ready while mem_req=0 ignored. Strobes (pc_we,ir_we,reg_we) are 1-cycle, Moore except
//   FETCH/BRANCH qualifiers; at most one PC write per instruction.
// STRUCTURE
//  Shared include mc_defines.v: state encodings, opcode constants, ALUOP_ADD/SUB/FUNCT,
//   ALUSRCB_* and PCSRC_* constants (shared with datapath and ALU control).
//  Sub-module alu_flag_reg: 4-bit flag register, sync reset, load enable.
//  Two-process FSM: registered state, combinational next-state/output decode.
// TESTING
//  R-type add, mem_ready=1: states FETCH,DECODE,EXEC_R,WB_R; reg_we=1 in cycle 4; flags latched.
//  R-type 0x7FFF+0x0001: flags=4'b0011 (ovf=1,sign=1) after EXEC_R; next lw leaves flags unchanged.
//  lw with mem_ready delayed 3 cycles in MEM_RD: mem_req held 4 cycles, WB_MEM once, total 8 cycles.
//  beq with alu_zero=1: pc_we=1,pc_src=01 in BRANCH; alu_zero=0: no pc_we; blt sign=1,ovf=0 taken.
//  opcode 4'hA: illegal=1, halted=1, all strobes 0 for 20 cycles; reset -> FETCH, illegal=0.
//  reset asserted in MEM_WR while waiting: next cycle state=FETCH, mem_req=0, mem_we=0, no writes.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcodes,
// ALU operation and operand-select codes, PC source codes and flag layout.
package multicycle_ctrl_fsm_pkg;

  localparam int OPW    = 4;
  localparam int STATEW = 4;

  typedef enum logic [STATEW-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_R     = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = 4'h0;
  localparam logic [OPW-1:0] OP_ADDI  = 4'h1;
  localparam logic [OPW-1:0] OP_LW    = 4'h2;
  localparam logic [OPW-1:0] OP_SW    = 4'h3;
  localparam logic [OPW-1:0] OP_BEQ   = 4'h4;
  localparam logic [OPW-1:0] OP_BNE   = 4'h5;
  localparam logic [OPW-1:0] OP_BLT   = 4'h6;
  localparam logic [OPW-1:0] OP_J     = 4'h7;
  localparam logic [OPW-1:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REGB = 2'b00;
  localparam logic [1:0] ALUSRCB_ONE  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Flag bit order matches the architectural register {zero,carry,overflow,sign}
  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic sign;
  } flags_t;

  // Branch condition evaluated on the live rs-rt compare result
  function automatic logic branchTaken(input logic [OPW-1:0] op, input flags_t f);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = f.zero;
      OP_BNE:  taken = ~f.zero;
      OP_BLT:  taken = f.sign ^ f.ovf;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Anything outside the defined instruction set ends in HALT with illegal set
  function automatic logic opLegal(input logic [OPW-1:0] op);
    return (op <= OP_J) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_flagreg.sv
// Architectural flag register: holds {zero,carry,overflow,sign} from the
// last flag-setting ALU instruction.
module alu_flag_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Load live ALU flags only when the controller asks for it
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit: walks each instruction through fetch, decode,
// execute, memory and writeback, driving ALU selects and the memory handshake.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           alu_zero,
  input  logic           alu_carry,
  input  logic           alu_ovf,
  input  logic           alu_sign,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           iord,
  output logic           ir_we,
  output logic           pc_we,
  output logic [1:0]     pc_src,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     aluop,
  output logic           reg_we,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic [3:0]     flags,
  output logic           halted,
  output logic           illegal
);

  state_t         state;
  state_t         nextState;
  logic [OPW-1:0] curOp;
  logic           flagWe;
  logic [3:0]     flagQ;
  logic           illegalQ;
  flags_t         liveFlags;

  assign liveFlags = '{zero: alu_zero, carry: alu_carry, ovf: alu_ovf, sign: alu_sign};

  // State register; reset returns to FETCH from anywhere, including mid-handshake
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else state <= nextState;
  end

  // Remember the decoded opcode so later states do not depend on IR staying put
  always_ff @(posedge clk) begin
    if (reset) curOp <= '0;
    else if (state == S_DECODE) curOp <= opcode;
  end

  // Sticky undefined-opcode indicator, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) illegalQ <= 1'b0;
    else if (state == S_DECODE && !opLegal(opcode)) illegalQ <= 1'b1;
  end

  // Next-state decode
  always_comb begin
    nextState = state;
    case (state)
      S_FETCH:    if (mem_ready) nextState = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:              nextState = S_EXEC_R;
          OP_ADDI:               nextState = S_EXEC_I;
          OP_LW, OP_SW:          nextState = S_MEM_ADDR;
          OP_BEQ, OP_BNE, OP_BLT: nextState = S_BRANCH;
          OP_J:                  nextState = S_JUMP;
          default:               nextState = S_HALT;
        endcase
      end
      S_EXEC_R:   nextState = S_WB_R;
      S_EXEC_I:   nextState = S_WB_I;
      S_MEM_ADDR: nextState = (curOp == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) nextState = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) nextState = S_FETCH;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: nextState = S_FETCH;
      S_HALT:     nextState = S_HALT;
      default:    nextState = S_FETCH;
    endcase
  end

  // Control outputs; all forced low while reset is asserted so nothing is written
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUSRCB_REGB;
    aluop      = ALUOP_ADD;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    flagWe     = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = ALUSRCB_ONE;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
        end
        S_DECODE: alu_src_b = ALUSRCB_IMM;
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          aluop     = ALUOP_FUNCT;
          flagWe    = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUSRCB_IMM;
          flagWe    = 1'b1;
        end
        S_WB_R: begin
          reg_we  = 1'b1;
          reg_dst = 1'b1;
        end
        S_WB_I: reg_we = 1'b1;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUSRCB_IMM;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_WB_MEM: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          aluop     = ALUOP_SUB;
          if (branchTaken(curOp, liveFlags)) begin
            pc_we  = 1'b1;
            pc_src = PCSRC_ALUOUT;
          end
        end
        S_JUMP: begin
          pc_we  = 1'b1;
          pc_src = PCSRC_JUMP;
        end
        S_HALT:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

  alu_flag_reg u_flags (
    .clk   (clk),
    .reset (reset),
    .load  (flagWe),
    .d     (liveFlags),
    .q     (flagQ)
  );

  assign flags   = reset ? 4'b0000 : flagQ;
  assign illegal = illegalQ & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: each scenario queues per-cycle
// stimulus with its expected control vector, then drains and compares.
module tb_multicycle_ctrl_fsm;

  typedef logic [20:0] vec_t;
  typedef struct packed {
    logic       rst;
    logic [3:0] op;
    logic       rdy;
    logic [3:0] alu;
  } stim_t;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       alu_zero, alu_carry, alu_ovf, alu_sign;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b, aluop;
  logic       reg_we, reg_dst, mem_to_reg;
  logic [3:0] flags;
  logic       halted, illegal;

  int compared   = 0;
  int mismatched = 0;

  stim_t stimQ[$];
  vec_t  expQ[$];
  string tagQ[$];

  multicycle_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .alu_ovf    (alu_ovf),
    .alu_sign   (alu_sign),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .aluop      (aluop),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .flags      (flags),
    .halted     (halted),
    .illegal    (illegal)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  // Expected control vector, same field order as the sampled observation
  function automatic vec_t mk(input logic mr, input logic mw, input logic io, input logic irw,
                              input logic pcw, input logic [1:0] pcs, input logic sa,
                              input logic [1:0] sb, input logic [1:0] op, input logic rw,
                              input logic rd, input logic m2r, input logic h, input logic il,
                              input logic [3:0] fl);
    return {mr, mw, io, irw, pcw, pcs, sa, sb, op, rw, rd, m2r, h, il, fl};
  endfunction

  function automatic vec_t eZero();
    return '0;
  endfunction
  function automatic vec_t eFetch(input logic rdy, input logic [3:0] fl);
    return mk(1'b1, 1'b0, 1'b0, rdy, rdy, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fl);
  endfunction
  function automatic vec_t eDecode(input logic [3:0] fl);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fl);
  endfunction
  function automatic vec_t eExecR(input logic [3:0] fl);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fl);
  endfunction
  function automatic vec_t eExecI(input logic [3:0] fl);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fl);
  endfunction
  function automatic vec_t eWb(input logic rd, input logic m2r, input logic [3:0] fl);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, rd, m2r, 1'b0, 1'b0, fl);
  endfunction
  function automatic vec_t eMemAddr(input logic [3:0] fl);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fl);
  endfunction
  function automatic vec_t eMem(input logic wr, input logic [3:0] fl);
    return mk(1'b1, wr, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fl);
  endfunction
  function automatic vec_t eBranch(input logic taken, input logic [3:0] fl);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, taken, {1'b0, taken}, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fl);
  endfunction
  function automatic vec_t eJump(input logic [3:0] fl);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fl);
  endfunction
  function automatic vec_t eHalt(input logic il, input logic [3:0] fl);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, il, fl);
  endfunction

  // Queue one cycle of stimulus together with the control vector it must produce
  task automatic applyStimulus(input logic rst, input logic [3:0] op, input logic rdy,
                               input logic [3:0] alu, input vec_t expv, input string tag);
    stim_t s;
    s.rst = rst;
    s.op  = op;
    s.rdy = rdy;
    s.alu = alu;
    stimQ.push_back(s);
    expQ.push_back(expv);
    tagQ.push_back(tag);
  endtask

  // Drive the next queued stimulus after the falling edge and sample outputs 1ns later
  task automatic stepCycle(output vec_t obs);
    stim_t s;
    s = stimQ.pop_front();
    @(negedge clk);
    reset     = s.rst;
    opcode    = s.op;
    mem_ready = s.rdy;
    {alu_zero, alu_carry, alu_ovf, alu_sign} = s.alu;
    #1;
    obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, aluop,
           reg_we, reg_dst, mem_to_reg, halted, illegal, flags};
  endtask

  task automatic test_reset();
    vec_t obs, expv;
    string tag;
    applyStimulus(1'b1, 4'h0, 1'b1, 4'hF, eZero(), "reset_c0");
    applyStimulus(1'b1, 4'h3, 1'b1, 4'hF, eZero(), "reset_c1");
    while (stimQ.size() != 0) begin
      stepCycle(obs);
      expv = expQ.pop_front();
      tag  = tagQ.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
    end
  endtask

  task automatic test_rtype();
    vec_t obs, expv;
    string tag;
    // 0x7FFF + 0x0001: zero=0 carry=0 ovf=1 sign=1
    applyStimulus(1'b0, 4'h0, 1'b1, 4'hF, eFetch(1'b1, 4'b0000), "rtype_fetch");
    applyStimulus(1'b0, 4'h0, 1'b1, 4'hF, eDecode(4'b0000), "rtype_decode");
    applyStimulus(1'b0, 4'h0, 1'b0, 4'b0011, eExecR(4'b0000), "rtype_exec");
    applyStimulus(1'b0, 4'h0, 1'b1, 4'hF, eWb(1'b1, 1'b0, 4'b0011), "rtype_wb");
    while (stimQ.size() != 0) begin
      stepCycle(obs);
      expv = expQ.pop_front();
      tag  = tagQ.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
    end
  endtask

  task automatic test_lw_delay();
    vec_t obs, expv;
    string tag;
    applyStimulus(1'b0, 4'h2, 1'b1, 4'hF, eFetch(1'b1, 4'b0011), "lw_fetch");
    applyStimulus(1'b0, 4'h2, 1'b1, 4'hF, eDecode(4'b0011), "lw_decode");
    applyStimulus(1'b0, 4'h2, 1'b1, 4'b1000, eMemAddr(4'b0011), "lw_addr");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 4'h2, 1'b0, 4'hF, eMem(1'b0, 4'b0011), $sformatf("lw_rd_wait%0d", i));
    applyStimulus(1'b0, 4'h2, 1'b1, 4'hF, eMem(1'b0, 4'b0011), "lw_rd_done");
    applyStimulus(1'b0, 4'h2, 1'b1, 4'hF, eWb(1'b0, 1'b1, 4'b0011), "lw_wbmem");
    while (stimQ.size() != 0) begin
      stepCycle(obs);
      expv = expQ.pop_front();
      tag  = tagQ.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
    end
  endtask

  task automatic test_addi();
    vec_t obs, expv;
    string tag;
    applyStimulus(1'b0, 4'h1, 1'b0, 4'hF, eFetch(1'b0, 4'b0011), "addi_fetch_stall");
    applyStimulus(1'b0, 4'h1, 1'b1, 4'hF, eFetch(1'b1, 4'b0011), "addi_fetch");
    applyStimulus(1'b0, 4'h1, 1'b0, 4'hF, eDecode(4'b0011), "addi_decode");
    applyStimulus(1'b0, 4'h1, 1'b0, 4'b1100, eExecI(4'b0011), "addi_exec");
    applyStimulus(1'b0, 4'h1, 1'b0, 4'hF, eWb(1'b0, 1'b0, 4'b1100), "addi_wb");
    while (stimQ.size() != 0) begin
      stepCycle(obs);
      expv = expQ.pop_front();
      tag  = tagQ.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
    end
  endtask

  task automatic test_sw();
    vec_t obs, expv;
    string tag;
    applyStimulus(1'b0, 4'h3, 1'b1, 4'h0, eFetch(1'b1, 4'b1100), "sw_fetch");
    applyStimulus(1'b0, 4'h3, 1'b0, 4'h0, eDecode(4'b1100), "sw_decode");
    applyStimulus(1'b0, 4'h3, 1'b1, 4'h0, eMemAddr(4'b1100), "sw_addr");
    applyStimulus(1'b0, 4'h3, 1'b1, 4'h0, eMem(1'b1, 4'b1100), "sw_wr");
    while (stimQ.size() != 0) begin
      stepCycle(obs);
      expv = expQ.pop_front();
      tag  = tagQ.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
    end
  endtask

  task automatic test_branch();
    vec_t obs, expv;
    string tag;
    logic [3:0] ops[6]   = '{4'h4, 4'h4, 4'h5, 4'h5, 4'h6, 4'h6};
    logic [3:0] alus[6]  = '{4'b1000, 4'b0000, 4'b0001, 4'b1000, 4'b0001, 4'b0011};
    logic       taken[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, ops[i], 1'b1, 4'h0, eFetch(1'b1, 4'b1100), $sformatf("br%0d_fetch", i));
      applyStimulus(1'b0, ops[i], 1'b1, 4'h0, eDecode(4'b1100), $sformatf("br%0d_decode", i));
      applyStimulus(1'b0, ops[i], 1'b1, alus[i], eBranch(taken[i], 4'b1100), $sformatf("br%0d_branch", i));
    end
    while (stimQ.size() != 0) begin
      stepCycle(obs);
      expv = expQ.pop_front();
      tag  = tagQ.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
    end
  endtask

  task automatic test_jump();
    vec_t obs, expv;
    string tag;
    applyStimulus(1'b0, 4'h7, 1'b1, 4'hF, eFetch(1'b1, 4'b1100), "j_fetch");
    applyStimulus(1'b0, 4'h7, 1'b1, 4'hF, eDecode(4'b1100), "j_decode");
    applyStimulus(1'b0, 4'h7, 1'b1, 4'hF, eJump(4'b1100), "j_jump");
    while (stimQ.size() != 0) begin
      stepCycle(obs);
      expv = expQ.pop_front();
      tag  = tagQ.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
    end
  endtask

  task automatic test_reset_midwr();
    vec_t obs, expv;
    string tag;
    applyStimulus(1'b0, 4'h3, 1'b1, 4'h0, eFetch(1'b1, 4'b1100), "rstwr_fetch");
    applyStimulus(1'b0, 4'h3, 1'b0, 4'h0, eDecode(4'b1100), "rstwr_decode");
    applyStimulus(1'b0, 4'h3, 1'b0, 4'h0, eMemAddr(4'b1100), "rstwr_addr");
    applyStimulus(1'b0, 4'h3, 1'b0, 4'h0, eMem(1'b1, 4'b1100), "rstwr_wait0");
    applyStimulus(1'b0, 4'h3, 1'b0, 4'h0, eMem(1'b1, 4'b1100), "rstwr_wait1");
    applyStimulus(1'b1, 4'h3, 1'b1, 4'hF, eZero(), "rstwr_reset");
    applyStimulus(1'b0, 4'h3, 1'b0, 4'hF, eFetch(1'b0, 4'b0000), "rstwr_after");
    while (stimQ.size() != 0) begin
      stepCycle(obs);
      expv = expQ.pop_front();
      tag  = tagQ.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
    end
  endtask

  task automatic test_illegal();
    vec_t obs, expv;
    string tag;
    logic r;
    applyStimulus(1'b0, 4'hA, 1'b1, 4'h0, eFetch(1'b1, 4'b0000), "ill_fetch");
    applyStimulus(1'b0, 4'hA, 1'b1, 4'h0, eDecode(4'b0000), "ill_decode");
    for (int i = 0; i < 20; i++) begin
      r = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, 4'hA, r, 4'hF, eHalt(1'b1, 4'b0000), $sformatf("ill_halt%0d", i));
    end
    applyStimulus(1'b1, 4'hA, 1'b1, 4'hF, eZero(), "ill_reset");
    applyStimulus(1'b0, 4'hA, 1'b0, 4'hF, eFetch(1'b0, 4'b0000), "ill_after");
    while (stimQ.size() != 0) begin
      stepCycle(obs);
      expv = expQ.pop_front();
      tag  = tagQ.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
    end
  endtask

  task automatic test_halt();
    vec_t obs, expv;
    string tag;
    applyStimulus(1'b0, 4'hF, 1'b1, 4'h0, eFetch(1'b1, 4'b0000), "halt_fetch");
    applyStimulus(1'b0, 4'hF, 1'b1, 4'h0, eDecode(4'b0000), "halt_decode");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 4'hF, 1'b1, 4'hF, eHalt(1'b0, 4'b0000), $sformatf("halt_hold%0d", i));
    applyStimulus(1'b1, 4'hF, 1'b0, 4'h0, eZero(), "halt_reset");
    applyStimulus(1'b0, 4'hF, 1'b1, 4'h0, eFetch(1'b1, 4'b0000), "halt_after");
    while (stimQ.size() != 0) begin
      stepCycle(obs);
      expv = expQ.pop_front();
      tag  = tagQ.pop_front();
      compared++;
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
    end
  endtask

  // Scenario sequence; each leaves the controller in FETCH for the next one
  initial begin
    reset     = 1'b1;
    opcode    = 4'h0;
    mem_ready = 1'b0;
    {alu_zero, alu_carry, alu_ovf, alu_sign} = 4'b0000;
    test_reset();
    test_rtype();
    test_lw_delay();
    test_addi();
    test_sw();
    test_branch();
    test_jump();
    test_reset_midwr();
    test_illegal();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
